// File: rtl/ft2232h_tx_feeder.sv
// ft2232h_tx_feeder
// Byte buffer and bus driver for the FT2232H synchronous-FIFO write side.
// User bytes enter a DEPTH-entry FIFO over a valid/ready handshake. A holding
// register owns the byte presented on ADBUS until the chip takes it, so a TXE#
// rise mid-burst never drops or duplicates a byte.

module ft2232h_tx_feeder #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          txe,
  output logic          wr,
  output logic [7:0]    data_out,
  output logic [AW:0]   level,
  output logic [15:0]   tx_count
);

  localparam logic [AW:0]   FULL_LEVEL = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   LEVEL_ZERO = '0;
  localparam logic [AW:0]   LEVEL_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // Storage
  logic [7:0]    ram_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   level_r;

  // Holding register: the byte currently owned by the bus
  logic          hold_valid_r;
  logic [7:0]    hold_data_r;

  // Bus side
  state_t        state_r;
  state_t        state_next_s;
  logic          wr_r;
  logic          wr_next_s;
  logic [7:0]    data_out_r;
  logic [7:0]    data_next_s;
  logic [15:0]   tx_count_r;

  // Handshake / transfer decode
  logic          full_s;
  logic          empty_s;
  logic          push_s;
  logic          pop_s;
  logic          xfer_s;
  logic          hold_valid_next_s;
  logic [7:0]    hold_data_next_s;
  logic [7:0]    head_data_s;

  assign full_s      = (level_r == FULL_LEVEL);
  assign empty_s     = (level_r == LEVEL_ZERO);
  assign in_ready    = ~full_s & ~reset;
  assign push_s      = in_valid & in_ready;
  // The chip takes the byte on any edge where WR# was driven low and TXE# is low
  assign xfer_s      = ~wr_r & ~txe;
  // Refill the holding register when it is empty or being emptied this edge
  assign pop_s       = (~hold_valid_r | xfer_s) & ~empty_s;
  assign head_data_s = ram_r[rd_ptr_r];

  // Next value of the holding register given this edge's pop and transfer
  always_comb begin
    hold_valid_next_s = hold_valid_r;
    hold_data_next_s  = hold_data_r;
    if (pop_s) begin
      hold_valid_next_s = 1'b1;
      hold_data_next_s  = head_data_s;
    end else if (xfer_s) begin
      hold_valid_next_s = 1'b0;
      hold_data_next_s  = hold_data_r;
    end else begin
      hold_valid_next_s = hold_valid_r;
      hold_data_next_s  = hold_data_r;
    end
  end

  // FIFO RAM write port; contents are discarded logically by pointer reset
  always_ff @(posedge clk) begin
    if (push_s) begin
      ram_r[wr_ptr_r] <= in_data;
    end
  end

  // Write/read pointers, wrapping modulo DEPTH
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Occupancy of FIFO storage; simultaneous push and pop cancel out
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_r <= LEVEL_ZERO;
    end else begin
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LEVEL_ONE;
        2'b01:   level_r <= level_r - LEVEL_ONE;
        default: level_r <= level_r;
      endcase
    end
  end

  // Holding register update
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_valid_r <= 1'b0;
      hold_data_r  <= 8'h00;
    end else begin
      hold_valid_r <= hold_valid_next_s;
      hold_data_r  <= hold_data_next_s;
    end
  end

  // Count bytes accepted by the chip, wrapping at 16 bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_count_r <= 16'h0000;
    end else if (xfer_s) begin
      tx_count_r <= tx_count_r + 16'h0001;
    end
  end

  // Bus FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Bus FSM next state: send while a byte is held and the chip has room
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (hold_valid_next_s & ~txe) begin
          state_next_s = ST_SEND;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (txe | ~hold_valid_next_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_SEND;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Bus FSM outputs: WR# low in SEND, bus shows the held byte or zero
  always_comb begin
    wr_next_s   = 1'b1;
    data_next_s = 8'h00;
    if (state_next_s == ST_SEND) begin
      wr_next_s = 1'b0;
    end else begin
      wr_next_s = 1'b1;
    end
    if (hold_valid_next_s) begin
      data_next_s = hold_data_next_s;
    end else begin
      data_next_s = 8'h00;
    end
  end

  // Registered pin drivers for WR# and ADBUS
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_r       <= 1'b1;
      data_out_r <= 8'h00;
    end else begin
      wr_r       <= wr_next_s;
      data_out_r <= data_next_s;
    end
  end

  assign wr       = wr_r;
  assign data_out = data_out_r;
  assign level    = level_r;
  assign tx_count = tx_count_r;

endmodule
